// File: rtl/pg_pkg.sv
// rtl/pg_pkg.sv - state encoding and output decode for the power-gating domain sequencer
package pg_pkg;

    localparam int PG_STATE_W = 4;

    typedef enum logic [PG_STATE_W-1:0] {
        PG_ON      = 4'd0,
        PG_DRAIN   = 4'd1,
        PG_CLAMP   = 4'd2,
        PG_SAVE    = 4'd3,
        PG_PWR_DN  = 4'd4,
        PG_OFF     = 4'd5,
        PG_PWR_UP  = 4'd6,
        PG_SETTLE  = 4'd7,
        PG_RST     = 4'd8,
        PG_RESTORE = 4'd9,
        PG_UNCLAMP = 4'd10
    } pgState_t;

    // Clamp stays up through UNCLAMP so it drops one cycle after the domain reset releases.
    function automatic logic pg_clamp_en(input pgState_t s);
        return !((s == PG_ON) || (s == PG_DRAIN));
    endfunction

    function automatic logic pg_pwr_en(input pgState_t s);
        return !((s == PG_PWR_DN) || (s == PG_OFF));
    endfunction

    function automatic logic pg_domain_rst(input pgState_t s);
        return (s == PG_CLAMP) || (s == PG_SAVE) || (s == PG_PWR_DN) || (s == PG_OFF) ||
               (s == PG_PWR_UP) || (s == PG_SETTLE) || (s == PG_RST);
    endfunction

    function automatic logic pg_busy(input pgState_t s);
        return !((s == PG_ON) || (s == PG_OFF));
    endfunction

endpackage

// File: rtl/pg_settle_counter.sv
// rtl/pg_settle_counter.sv - loadable down-counter that parks at zero, shared by SETTLE and RST waits
module pg_settle_counter
    import pg_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pg_domain_sequencer.sv
// rtl/pg_domain_sequencer.sv - per-domain clamp/sleep-switch/reset sequencer
// Optional retention handshake (save_o/restore_o/retDone_i) enabled by PG_RETENTION_EN.
module pg_domain_sequencer
    import pg_pkg::*;
#(
    parameter int SETTLE_W   = 4,
    parameter int RST_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                gateReq_i,
    input  logic                domainIdle_i,
    input  logic                pwrAck_i,
    input  logic [SETTLE_W-1:0] settleCfg_i,
`ifdef PG_RETENTION_EN
    input  logic                retDone_i,
    output logic                save_o,
    output logic                restore_o,
`endif
    output logic                clampEn_o,
    output logic                pwrEn_o,
    output logic                domainRst_o,
    output logic                domainOn_o,
    output logic                busy_o
);

    localparam logic [SETTLE_W-1:0] RST_LOAD = SETTLE_W'(RST_CYCLES - 1);

    pgState_t            state_q;
    pgState_t            state_d;
    logic                cnt_load;
    logic [SETTLE_W-1:0] cnt_value;
    logic                cnt_zero;
    logic [SETTLE_W-1:0] settle_load;

    logic clamp_q;
    logic pwr_q;
    logic drst_q;
    logic on_q;
    logic busy_q;

    // The counter exits on zero, so load one less; cfg=0 still spends one cycle in SETTLE.
    assign settle_load = (settleCfg_i == '0) ? '0 : settleCfg_i - SETTLE_W'(1);

    pg_settle_counter #(
        .W (SETTLE_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (reset_n),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .zero_o  (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        cnt_load  = 1'b0;
        cnt_value = settle_load;
        case (state_q)
            PG_ON: begin
                if (gateReq_i) state_d = PG_DRAIN;
            end
            PG_DRAIN: begin
                if (!gateReq_i) begin
                    state_d = PG_ON;
                end else if (domainIdle_i) begin
                    state_d = PG_CLAMP;
                end
            end
            PG_CLAMP: begin
`ifdef PG_RETENTION_EN
                state_d = PG_SAVE;
`else
                state_d = PG_PWR_DN;
`endif
            end
`ifdef PG_RETENTION_EN
            PG_SAVE: begin
                if (retDone_i) state_d = PG_PWR_DN;
            end
`endif
            PG_PWR_DN: begin
                if (!pwrAck_i) state_d = PG_OFF;
            end
            PG_OFF: begin
                if (!gateReq_i) state_d = PG_PWR_UP;
            end
            PG_PWR_UP: begin
                if (pwrAck_i) begin
                    state_d   = PG_SETTLE;
                    cnt_load  = 1'b1;
                    cnt_value = settle_load;
                end
            end
            PG_SETTLE: begin
                if (cnt_zero) begin
                    state_d   = PG_RST;
                    cnt_load  = 1'b1;
                    cnt_value = RST_LOAD;
                end
            end
            PG_RST: begin
                if (cnt_zero) begin
`ifdef PG_RETENTION_EN
                    state_d = PG_RESTORE;
`else
                    state_d = PG_UNCLAMP;
`endif
                end
            end
`ifdef PG_RETENTION_EN
            PG_RESTORE: begin
                if (retDone_i) state_d = PG_UNCLAMP;
            end
`endif
            PG_UNCLAMP: begin
                state_d = PG_ON;
            end
            default: begin
                state_d = PG_ON;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PG_ON;
            clamp_q <= 1'b0;
            pwr_q   <= 1'b1;
            drst_q  <= 1'b0;
            on_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clamp_q <= pg_clamp_en(state_d);
            pwr_q   <= pg_pwr_en(state_d);
            drst_q  <= pg_domain_rst(state_d);
            on_q    <= (state_d == PG_ON);
            busy_q  <= pg_busy(state_d);
        end
    end

`ifdef PG_RETENTION_EN
    logic save_q;
    logic restore_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            save_q    <= 1'b0;
            restore_q <= 1'b0;
        end else begin
            save_q    <= (state_d == PG_SAVE) && (state_q != PG_SAVE);
            restore_q <= (state_d == PG_RESTORE) && (state_q != PG_RESTORE);
        end
    end

    assign save_o    = save_q;
    assign restore_o = restore_q;
`endif

    assign clampEn_o   = clamp_q;
    assign pwrEn_o     = pwr_q;
    assign domainRst_o = drst_q;
    assign domainOn_o  = on_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// tb/tb_pg_domain_sequencer.sv - directed self-checking bench for pg_domain_sequencer
module tb_pg_domain_sequencer;

    localparam int SETTLE_W   = 4;
    localparam int RST_CYCLES = 4;
`ifdef PG_RETENTION_EN
    localparam int RET_EXTRA  = 4;
`else
    localparam int RET_EXTRA  = 0;
`endif

    // {clampEn, pwrEn, domainRst, domainOn, busy}
    localparam logic [4:0] O_ON      = 5'b01010;
    localparam logic [4:0] O_DRAIN   = 5'b01001;
    localparam logic [4:0] O_CLAMP   = 5'b11101;
    localparam logic [4:0] O_PWR_DN  = 5'b10101;
    localparam logic [4:0] O_OFF     = 5'b10100;
    localparam logic [4:0] O_WAKE    = 5'b11101;
    localparam logic [4:0] O_UNCLAMP = 5'b11001;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                gateReq_i;
    logic                domainIdle_i;
    logic                pwrAck_i;
    logic [SETTLE_W-1:0] settleCfg_i;
    logic                clampEn_o;
    logic                pwrEn_o;
    logic                domainRst_o;
    logic                domainOn_o;
    logic                busy_o;
    logic [4:0]          outs;
`ifdef PG_RETENTION_EN
    logic                retDone_i;
    logic                save_o;
    logic                restore_o;
    int                  ret_cnt = 0;
`endif

    int   n_checks = 0;
    int   n_pass   = 0;
    int   inv_viol = 0;
    bit   auto_ack = 1'b0;
    logic [1:0] ack_pipe = 2'b11;

    assign outs = {clampEn_o, pwrEn_o, domainRst_o, domainOn_o, busy_o};

    pg_domain_sequencer #(
        .SETTLE_W   (SETTLE_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gateReq_i    (gateReq_i),
        .domainIdle_i (domainIdle_i),
        .pwrAck_i     (pwrAck_i),
        .settleCfg_i  (settleCfg_i),
`ifdef PG_RETENTION_EN
        .retDone_i    (retDone_i),
        .save_o       (save_o),
        .restore_o    (restore_o),
`endif
        .clampEn_o    (clampEn_o),
        .pwrEn_o      (pwrEn_o),
        .domainRst_o  (domainRst_o),
        .domainOn_o   (domainOn_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            if (!pwrEn_o && !clampEn_o) inv_viol++;
            if (domainOn_o && (clampEn_o || domainRst_o)) inv_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; the power switch model echoes pwrEn_o two cycles late.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            ack_pipe  = {ack_pipe[0], pwrEn_o};
            pwrAck_i  = ack_pipe[1];
        end
`ifdef PG_RETENTION_EN
        if (save_o || restore_o) begin
            ret_cnt   = 3;
            retDone_i = 1'b0;
        end else if (ret_cnt > 0) begin
            ret_cnt--;
            retDone_i = (ret_cnt == 0);
        end else begin
            retDone_i = 1'b0;
        end
`endif
    endtask

    task automatic wait_outs(input logic [4:0] exp, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (outs === exp) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        reset_n      = 1'b0;
        gateReq_i    = 1'b0;
        domainIdle_i = 1'b0;
        pwrAck_i     = 1'b1;
        settleCfg_i  = '0;
`ifdef PG_RETENTION_EN
        retDone_i    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs, O_ON);
        reset_n = 1'b1;

        bad = 0;
        repeat (20) begin
            step();
            if (outs !== O_ON) bad++;
        end
        check("idle_stays_on", bad, 0);

        // Full gate with a hand-driven power switch
        gateReq_i    = 1'b1;
        domainIdle_i = 1'b1;
        step();
        check("gate_drain", outs, O_DRAIN);
        step();
        check("gate_clamp", outs, O_CLAMP);
        repeat (RET_EXTRA) step();
        step();
        check("gate_pwr_dn", outs, O_PWR_DN);
        step();
        step();
        pwrAck_i = 1'b0;
        check("gate_wait_ack", outs, O_PWR_DN);
        step();
        check("gate_off", outs, O_OFF);

        // Wake with settleCfg=5; ack seen on the fourth edge after leaving OFF
        settleCfg_i = 4'd5;
        gateReq_i   = 1'b0;
        step();
        check("wake_pwr_up", outs, O_WAKE);
        step();
        step();
        pwrAck_i = 1'b1;
        step();
        wait_outs(O_UNCLAMP, 30, n);
        check("wake_rst_fall", n, 5 + RST_CYCLES);
        repeat (RET_EXTRA) step();
        step();
        check("wake_on", outs, O_ON);

        // Drain abort
        auto_ack     = 1'b1;
        ack_pipe     = 2'b11;
        gateReq_i    = 1'b1;
        domainIdle_i = 1'b0;
        bad = 0;
        repeat (10) begin
            step();
            if (clampEn_o || !pwrEn_o || domainOn_o) bad++;
        end
        check("abort_no_clamp", bad, 0);
        gateReq_i = 1'b0;
        step();
        check("abort_on", outs, O_ON);

        // Gate with modelled switch: DRAIN, CLAMP, PWR_DN, two-cycle ack lag, OFF
        gateReq_i    = 1'b1;
        domainIdle_i = 1'b1;
        wait_outs(O_OFF, 40, n);
        check("gate2_latency", n, 5 + RET_EXTRA);

        // settleCfg=0 boundary: 2 cycles PWR_UP, 1 cycle SETTLE, RST_CYCLES in RST
        settleCfg_i = '0;
        gateReq_i   = 1'b0;
        wait_outs(O_UNCLAMP, 40, n);
        check("wake0_rst_fall", n, 3 + 1 + RST_CYCLES);
        repeat (RET_EXTRA) step();
        step();
        check("wake0_on", outs, O_ON);

        // Re-gate during SETTLE: wake completes, then DRAIN
        gateReq_i = 1'b1;
        wait_outs(O_OFF, 40, n);
        check("gate3_latency", n, 5 + RET_EXTRA);
        settleCfg_i = 4'd3;
        gateReq_i   = 1'b0;
        step();
        step();
        step();
        gateReq_i = 1'b1;
        wait_outs(O_ON, 40, n);
        check("regate_wake_done", n, 8 + RET_EXTRA);
        step();
        check("regate_drain", outs, O_DRAIN);

        // Async reset while in PWR_DN
        wait_outs(O_PWR_DN, 20, n);
        check("reach_pwr_dn", n, 2 + RET_EXTRA);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", outs, O_ON);
        gateReq_i = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_reset_on", outs, O_ON);

`ifdef PG_RETENTION_EN
        begin
            int  saves;
            int  restores;
            int  viol;
            bit  done_seen;
            saves     = 0;
            restores  = 0;
            viol      = 0;
            done_seen = 1'b0;
            gateReq_i = 1'b1;
            for (int i = 0; i < 40 && outs !== O_OFF; i++) begin
                step();
                if (save_o) saves++;
                if (!pwrEn_o && !done_seen) viol++;
                if (retDone_i) done_seen = 1'b1;
            end
            done_seen = 1'b0;
            gateReq_i = 1'b0;
            for (int i = 0; i < 60 && outs !== O_ON; i++) begin
                step();
                if (restore_o) restores++;
                if (!clampEn_o && !done_seen) viol++;
                if (retDone_i) done_seen = 1'b1;
            end
            check("ret_save_pulses", saves, 1);
            check("ret_restore_pulses", restores, 1);
            check("ret_hold_until_done", viol, 0);
            check("ret_back_on", outs, O_ON);
        end
`endif

        check("invariants", inv_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
